// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID/EX stage: ALU op codes, ALUOp and
// funct encodings, forwarding selects and the stage register layout.
package mips_pkg;

    // ALU operation codes seen by the 32-bit ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    // R-type funct fields
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // Main-decoder ALUOp encoding
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    // Operand source selection
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // Everything captured from decode
    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr_reg;
        aluop_e      aluop;
        logic [5:0]  funct;
        logic        alusrc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
    } idex_regs_t;

    // A writer targets a source index; register 0 never counts as a match
    function automatic logic dest_hit(input logic en, input logic [4:0] dst,
                                      input logic [4:0] src);
        return en & (src != 5'd0) & (dst == src);
    endfunction

    // EX/MEM is the younger result, so it wins when both stages match
    function automatic fwd_sel_e fwd_select(input logic exmem_we, input logic [4:0] exmem_dst,
                                            input logic memwb_we, input logic [4:0] memwb_dst,
                                            input logic [4:0] src);
        if (dest_hit(exmem_we, exmem_dst, src)) begin
            return FWD_EXMEM;
        end else if (dest_hit(memwb_we, memwb_dst, src)) begin
            return FWD_MEMWB;
        end else begin
            return FWD_REG;
        end
    endfunction

endpackage

// File: rtl/alu_control.sv
// ALU control: turns the registered ALUOp / funct pair into the 4-bit ALU op code.
// Unknown R-type funct values map to ALU_NOP so the ALU produces zero.
module alu_control
    import mips_pkg::*;
(
    input  aluop_e      alu_op_i,
    input  logic [5:0]  funct_i,
    output logic [3:0]  op_code_o
);

    // Decode ALUOp, falling through to funct for R-type instructions
    always_comb begin
        op_code_o = ALU_NOP;
        case (alu_op_i)
            ALUOP_ADD: op_code_o = ALU_ADD;
            ALUOP_SUB: op_code_o = ALU_SUB;
            ALUOP_OR:  op_code_o = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: op_code_o = ALU_ADD;
                    FUNCT_SUB: op_code_o = ALU_SUB;
                    FUNCT_AND: op_code_o = ALU_AND;
                    FUNCT_OR:  op_code_o = ALU_OR;
                    FUNCT_SLT: op_code_o = ALU_SLT;
                    FUNCT_NOR: op_code_o = ALU_NOR;
                    default:   op_code_o = ALU_NOP;
                endcase
            end
            default: op_code_o = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage feeding the ALU: registers decode results, drives the
// ALU operands through EX/MEM and MEM/WB forwarding, and flags hazards.
// Build option ID_EX_FWD_EN: when defined, operands are forwarded and only
// load-use hazards stall; otherwise operands come straight from the stage
// registers and any in-flight write to a decode source requests a stall.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [1:0]  aluOp,
    input  logic [5:0]  funct,
    input  logic        aluSrc,
    input  logic        regDst,
    input  logic        regWrite,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        memToReg,
    input  logic        exmem_regWrite,
    input  logic        memwb_regWrite,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  opCode,
    output logic [31:0] store_data,
    output logic [4:0]  wr_reg,
    output logic        out_valid,
    output logic        regWrite_q,
    output logic        memRead_q,
    output logic        memWrite_q,
    output logic        memToReg_q,
    output logic        hazard_stall
);

    idex_regs_t  stage_d;
    idex_regs_t  stage_q;
    logic [31:0] rs_fwd_s;
    logic [31:0] rt_fwd_s;
    logic        load_use_s;

    // Next stage contents: flush beats stall, stall holds, otherwise capture
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!stall) begin
            stage_d.valid    = in_valid;
            stage_d.rs_data  = rs_data;
            stage_d.rt_data  = rt_data;
            stage_d.imm      = imm;
            stage_d.rs       = rs;
            stage_d.rt       = rt;
            stage_d.wr_reg   = regDst ? rd : rt;
            stage_d.aluop    = aluop_e'(aluOp);
            stage_d.funct    = funct;
            stage_d.alusrc   = aluSrc;
            stage_d.regwrite = in_valid & regWrite;
            stage_d.memread  = in_valid & memRead;
            stage_d.memwrite = in_valid & memWrite;
            stage_d.memtoreg = in_valid & memToReg;
        end else begin
            stage_d = stage_q;
        end
    end

    // Stage register with asynchronous clear to a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    alu_control u_alu_control (
        .alu_op_i  (stage_q.aluop),
        .funct_i   (stage_q.funct),
        .op_code_o (opCode)
    );

    assign load_use_s = stage_q.valid & stage_q.memread & (stage_q.wr_reg != 5'd0) &
                        ((stage_q.wr_reg == rs) | (stage_q.wr_reg == rt));

`ifdef ID_EX_FWD_EN
    fwd_sel_e rs_sel_s;
    fwd_sel_e rt_sel_s;

    assign rs_sel_s = fwd_select(exmem_regWrite, exmem_rd, memwb_regWrite, memwb_rd, stage_q.rs);
    assign rt_sel_s = fwd_select(exmem_regWrite, exmem_rd, memwb_regWrite, memwb_rd, stage_q.rt);

    // Forwarding muxes for both source operands
    always_comb begin
        rs_fwd_s = stage_q.rs_data;
        rt_fwd_s = stage_q.rt_data;
        case (rs_sel_s)
            FWD_EXMEM: rs_fwd_s = exmem_result;
            FWD_MEMWB: rs_fwd_s = memwb_result;
            default:   rs_fwd_s = stage_q.rs_data;
        endcase
        case (rt_sel_s)
            FWD_EXMEM: rt_fwd_s = exmem_result;
            FWD_MEMWB: rt_fwd_s = memwb_result;
            default:   rt_fwd_s = stage_q.rt_data;
        endcase
    end

    assign hazard_stall = load_use_s;
`else
    logic raw_s;
    logic unused_fwd_s;

    assign rs_fwd_s = stage_q.rs_data;
    assign rt_fwd_s = stage_q.rt_data;

    // Without forwarding, any pending write to a decode source must drain first
    always_comb begin
        raw_s = dest_hit(stage_q.regwrite, stage_q.wr_reg, rs) |
                dest_hit(stage_q.regwrite, stage_q.wr_reg, rt) |
                dest_hit(exmem_regWrite, exmem_rd, rs) |
                dest_hit(exmem_regWrite, exmem_rd, rt) |
                dest_hit(memwb_regWrite, memwb_rd, rs) |
                dest_hit(memwb_regWrite, memwb_rd, rt);
    end

    assign hazard_stall = load_use_s | raw_s;
    assign unused_fwd_s = ^{exmem_result, memwb_result, stage_q.rs, stage_q.rt};
`endif

    assign A          = rs_fwd_s;
    assign B          = stage_q.alusrc ? stage_q.imm : rt_fwd_s;
    assign store_data = rt_fwd_s;
    assign wr_reg     = stage_q.wr_reg;
    assign out_valid  = stage_q.valid;
    assign regWrite_q = stage_q.regwrite;
    assign memRead_q  = stage_q.memread;
    assign memWrite_q = stage_q.memwrite;
    assign memToReg_q = stage_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations adapt to
// whether ID_EX_FWD_EN is defined for the build.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, stall, flush;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  aluOp;
    logic [5:0]  funct;
    logic        aluSrc, regDst, regWrite, memRead, memWrite, memToReg;
    logic        exmem_regWrite, memwb_regWrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] A, B, store_data;
    logic [3:0]  opCode;
    logic [4:0]  wr_reg;
    logic        out_valid, regWrite_q, memRead_q, memWrite_q, memToReg_q, hazard_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .rs(rs), .rt(rt), .rd(rd), .aluOp(aluOp), .funct(funct),
        .aluSrc(aluSrc), .regDst(regDst), .regWrite(regWrite), .memRead(memRead),
        .memWrite(memWrite), .memToReg(memToReg),
        .exmem_regWrite(exmem_regWrite), .memwb_regWrite(memwb_regWrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .A(A), .B(B), .opCode(opCode), .store_data(store_data), .wr_reg(wr_reg),
        .out_valid(out_valid), .regWrite_q(regWrite_q), .memRead_q(memRead_q),
        .memWrite_q(memWrite_q), .memToReg_q(memToReg_q), .hazard_stall(hazard_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        rs_data = 32'd0; rt_data = 32'd0; imm = 32'd0;
        rs = 5'd0; rt = 5'd0; rd = 5'd0; aluOp = 2'b00; funct = 6'd0;
        aluSrc = 1'b0; regDst = 1'b0; regWrite = 1'b0; memRead = 1'b0;
        memWrite = 1'b0; memToReg = 1'b0;
        exmem_regWrite = 1'b0; memwb_regWrite = 1'b0;
        exmem_rd = 5'd0; memwb_rd = 5'd0; exmem_result = 32'd0; memwb_result = 32'd0;
    endtask

    // ALU control vectors: aluOp, funct, expected op code
    logic [1:0] tv_op [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] tv_fn [9] = '{6'b100100, 6'b100000, 6'b000000, 6'b100010, 6'b100100,
                              6'b100101, 6'b101010, 6'b100111, 6'b000000};
    logic [3:0] tv_ex [9] = '{4'b0010, 4'b0110, 4'b0001, 4'b0110, 4'b0000,
                              4'b0001, 4'b0111, 4'b1100, 4'b1111};

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_A", A, 32'd0);
        check_eq("rst_B", B, 32'd0);
        check_eq("rst_opcode", {28'd0, opCode}, 32'h2);
        check_eq("rst_ctrl", {27'd0, regWrite_q, memRead_q, memWrite_q, memToReg_q, hazard_stall}, 32'd0);
        rst = 1'b0;
        tick();

        // R-type add, no hazards
        in_valid = 1'b1; rs = 5'd1; rt = 5'd2; rd = 5'd3; rs_data = 32'd5; rt_data = 32'd7;
        aluOp = 2'b10; funct = 6'b100000; regDst = 1'b1; regWrite = 1'b1;
        tick();
        check_eq("add_A", A, 32'd5);
        check_eq("add_B", B, 32'd7);
        check_eq("add_opcode", {28'd0, opCode}, 32'h2);
        check_eq("add_valid", {31'd0, out_valid}, 32'd1);
        check_eq("add_wr_reg", {27'd0, wr_reg}, 32'd3);
        check_eq("add_regwrite", {31'd0, regWrite_q}, 32'd1);

        // Stall three cycles while decode inputs change
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rs_data = 32'h100 + i; rt_data = 32'h200 + i; in_valid = i[0];
            aluOp = 2'b01; rd = 5'd9; regWrite = 1'b0;
            tick();
            check_eq("stall_A", A, 32'd5);
            check_eq("stall_B", B, 32'd7);
            check_eq("stall_opcode", {28'd0, opCode}, 32'h2);
            check_eq("stall_valid_wr", {26'd0, out_valid, wr_reg}, {26'd0, 1'b1, 5'd3});
        end

        // Forwarding: sub with rs=3, rt=5
        stall = 1'b0; in_valid = 1'b1; rs = 5'd3; rt = 5'd5; rd = 5'd6;
        rs_data = 32'h11; rt_data = 32'h22; aluOp = 2'b10; funct = 6'b100010;
        regDst = 1'b1; regWrite = 1'b1;
        tick();
        stall = 1'b1; rs = 5'd3; rt = 5'd0;
        exmem_regWrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
        memwb_regWrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBB;
        #1;
        check_eq("fwd_tie_A", A, FWD ? 32'hAA : 32'h11);
        check_eq("fwd_tie_haz", {31'd0, hazard_stall}, FWD ? 32'd0 : 32'd1);
        check_eq("fwd_opcode", {28'd0, opCode}, 32'h6);
        memwb_rd = 5'd5;
        #1;
        check_eq("fwd_rt_store", store_data, FWD ? 32'hBB : 32'h22);
        check_eq("fwd_rt_B", B, FWD ? 32'hBB : 32'h22);
        check_eq("fwd_exmem_A", A, FWD ? 32'hAA : 32'h11);
        exmem_regWrite = 1'b0; memwb_rd = 5'd3;
        #1;
        check_eq("fwd_memwb_A", A, FWD ? 32'hBB : 32'h11);
        check_eq("fwd_memwb_haz", {31'd0, hazard_stall}, FWD ? 32'd0 : 32'd1);
        tick();
        check_eq("stall_fwd_hold", {31'd0, out_valid}, 32'd1);

        // rs = 0 never forwards
        stall = 1'b0; rs = 5'd0; rt = 5'd0; rs_data = 32'h33;
        exmem_regWrite = 1'b1; exmem_rd = 5'd0; memwb_regWrite = 1'b1; memwb_rd = 5'd0;
        tick();
        check_eq("fwd_r0_A", A, 32'h33);
        check_eq("fwd_r0_haz", {31'd0, hazard_stall}, 32'd0);
        exmem_regWrite = 1'b0; memwb_regWrite = 1'b0;

        // ALU control table
        rd = 5'd0; regWrite = 1'b0;
        for (int i = 0; i < 9; i++) begin
            aluOp = tv_op[i]; funct = tv_fn[i];
            tick();
            check_eq($sformatf("aluctl_%0d", i), {28'd0, opCode}, {28'd0, tv_ex[i]});
        end

        // Load word rt=4 with immediate operand
        clear_inputs();
        in_valid = 1'b1; rs = 5'd2; rt = 5'd4; rs_data = 32'h1000; imm = 32'hFFFFFFFC;
        aluSrc = 1'b1; aluOp = 2'b00; regWrite = 1'b1; memRead = 1'b1; memToReg = 1'b1;
        tick();
        check_eq("lw_B", B, 32'hFFFFFFFC);
        check_eq("lw_opcode", {28'd0, opCode}, 32'h2);
        check_eq("lw_ctrl", {27'd0, wr_reg}, 32'd4);
        check_eq("lw_memread", {30'd0, memRead_q, memToReg_q}, 32'd3);
        stall = 1'b1; rs = 5'd7; rt = 5'd4;
        #1;
        check_eq("loaduse_haz", {31'd0, hazard_stall}, 32'd1);
        rt = 5'd9;
        #1;
        check_eq("loaduse_nohaz", {31'd0, hazard_stall}, 32'd0);

        // Load into r0 never stalls
        stall = 1'b0; rs = 5'd2; rt = 5'd0;
        tick();
        stall = 1'b1; rs = 5'd0; rt = 5'd0;
        #1;
        check_eq("loaduse_r0", {26'd0, memRead_q, hazard_stall, wr_reg}, {26'd0, 1'b1, 1'b0, 5'd0});

        // Invalid instruction gates control
        stall = 1'b0; in_valid = 1'b0; regWrite = 1'b1; memWrite = 1'b1; rt = 5'd8;
        tick();
        check_eq("invalid_ctrl", {27'd0, out_valid, regWrite_q, memRead_q, memWrite_q, memToReg_q}, 32'd0);

        // Stall and flush together produce a bubble
        in_valid = 1'b1; rs_data = 32'h55; rs = 5'd1; rd = 5'd12; regDst = 1'b1;
        memRead = 1'b0; memToReg = 1'b0;
        tick();
        check_eq("pre_flush", {29'd0, out_valid, regWrite_q, memWrite_q}, 32'd7);
        stall = 1'b1; flush = 1'b1;
        tick();
        check_eq("flush_ctrl", {29'd0, out_valid, regWrite_q, memWrite_q}, 32'd0);
        check_eq("flush_data", A, 32'd0);
        check_eq("flush_wr_reg", {27'd0, wr_reg}, 32'd0);

        // Asynchronous reset mid-stream
        stall = 1'b0; flush = 1'b0;
        tick();
        check_eq("pre_rst", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0; regWrite = 1'b0; memWrite = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst", {23'd0, out_valid, regWrite_q, memWrite_q, wr_reg, memRead_q},
                 32'd0);
        check_eq("async_rst_A", A, 32'd0);
        check_eq("async_rst_op", {28'd0, opCode}, 32'h2);
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
